apb_master_bridge: RTL and testbench
====================================

// Module: apb_master_bridge
// PURPOSE
//   Converts a simple valid/ready command stream into APB transfers on the shared
//   APB bus interface, and returns one response per command. It sits directly
//   upstream of the bus: it is the master that drives the addr/sel/penable/write/
//   wdata/strb/prot wires and samples rdata/ready/slverr from the selected slave.
//   It adds a wait-state timeout so a hung slave cannot stall the master forever.
// PARAMETERS
//   ADDR_WIDTH  32  APB address width (matches APB_ADDR_WIDTH)
//   DATA_WIDTH  32  APB data width (matches APB_DATA_WIDTH); multiple of 8
//   TIMEOUT     16  max ACCESS cycles waiting on pready; 0 = timeout disabled
// PORTS
//   clk          in   1             clock, all logic on rising edge
//   rst          in   1             asynchronous reset, active-high
//   cmd_valid    in   1             command present
//   cmd_ready    out  1             command accepted when cmd_valid & cmd_ready
//   cmd_addr     in   ADDR_WIDTH    transfer address
//   cmd_write    in   1             1 = write, 0 = read
//   cmd_wdata    in   DATA_WIDTH    write data
//   cmd_strb     in   DATA_WIDTH/8  write byte strobes (forced 0 on reads)
//   cmd_prot     in   3             protection attributes
//   rsp_valid    out  1             one-cycle pulse: transfer finished
//   rsp_rdata    out  DATA_WIDTH    read data (0 for writes/timeouts)
//   rsp_err      out  1             slverr or timeout
//   rsp_timeout  out  1             transfer aborted by timeout
//   paddr        out  ADDR_WIDTH    APB address
//   psel         out  1             APB select
//   penable      out  1             APB enable
//   pwrite       out  1             APB direction
//   pwdata       out  DATA_WIDTH    APB write data
//   pstrb        out  DATA_WIDTH/8  APB strobes
//   pprot        out  3             APB protection
//   prdata       in   DATA_WIDTH    APB read data
//   pready       in   1             APB ready from slave
//   pslverr      in   1             APB slave error
// BEHAVIOUR
//   - Reset (async, rst=1): state IDLE; all outputs 0; wait counter 0.
//   - FSM: IDLE -> SETUP on cmd accept; SETUP -> ACCESS always (1 cycle);
//     ACCESS -> ACCESS while !pready and not timed out; on pready: SETUP if a new
//     command is accepted in that cycle, else IDLE; on timeout -> IDLE.
//   - cmd_ready = (state==IDLE) | (state==ACCESS & pready). Combinational from
//     pready by design; no other command is accepted in SETUP/ACCESS.
//   - On accept, the command is registered; paddr/pwrite/pwdata/pstrb/pprot are
//     driven from these registers and held stable through SETUP and ACCESS.
//   - SETUP: psel=1, penable=0. ACCESS: psel=1, penable=1. IDLE: psel=penable=0;
//     bus data outputs hold last values.
//   - Back-to-back: psel stays 1, penable drops for exactly one SETUP cycle.
//   - Completion (ACCESS & pready): next cycle rsp_valid=1, rsp_rdata=prdata
//     (reads) or 0 (writes), rsp_err=pslverr, rsp_timeout=0. pslverr only
//     sampled when pready=1. Latency cmd accept -> rsp_valid = 3 + wait states.
//   - Wait counter: cleared on entering ACCESS, +1 each ACCESS cycle with
//     pready=0. When it reaches TIMEOUT while pready=0 (TIMEOUT!=0): psel and
//     penable drop next cycle, rsp_valid=1, rsp_err=1, rsp_timeout=1,
//     rsp_rdata=0. pready=1 in the same cycle the limit is hit wins (normal).
//   - rsp_valid has no backpressure; rsp_* fields are 0 when rsp_valid=0.
//   - Reset mid-transfer: bus aborts immediately (psel/penable 0), no response.
// TESTING
//   1. Write addr=0x10, wdata=0xA5A5_A5A5, strb=0xF, slave pready=1 in ACCESS ->
//      psel 2 cycles, penable 1 cycle, rsp_valid 1 cycle later, rsp_err=0.
//   2. Read addr=0x20, slave inserts 3 wait states then prdata=0x1234_5678 ->
//      penable high 4 cycles, rsp_rdata=0x1234_5678, latency 6 cycles.
//   3. Two commands held valid back-to-back -> psel stays 1, penable low for
//      exactly one cycle between transfers, two rsp_valid pulses, ordered.
//   4. Slave answers pready=1,pslverr=1 -> rsp_err=1, rsp_timeout=0; slave never
//      ready with TIMEOUT=16 -> abort after 16 wait cycles, rsp_err=rsp_timeout=1.
//   5. Assert rst during ACCESS -> psel/penable/rsp_valid 0 same cycle (async),
//      next command after release runs normally.

Source files
------------

// File: rtl/apb_master_bridge.sv
// ---------------------------------------------------------------------------
// apb_master_bridge
//
// Turns a valid/ready command stream into APB transfers and returns exactly
// one response pulse per command. It is the APB master: it drives the
// address/select/enable/direction/data/strobe/protection wires and samples
// read data, ready and slave error from the selected slave. A wait-state
// timeout aborts a transfer whose slave never raises pready.
//
// Parameters
//   ADDR_WIDTH  APB address width
//   DATA_WIDTH  APB data width (multiple of 8)
//   TIMEOUT     max ACCESS wait cycles before abort; 0 disables the timeout
//
// Ports
//   clk, rst                    clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready         command handshake
//   cmd_addr/write/wdata/strb/prot  command fields (strobes zeroed for reads)
//   rsp_valid                   one-cycle completion pulse
//   rsp_rdata/err/timeout       response fields, all 0 when rsp_valid=0
//   paddr/psel/penable/pwrite/pwdata/pstrb/pprot   APB master outputs
//   prdata/pready/pslverr       APB slave inputs
// ---------------------------------------------------------------------------
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic                    cmd_write,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  input  logic [2:0]              cmd_prot,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [2:0]              pprot,
  input  logic [DATA_WIDTH-1:0]   prdata,
  input  logic                    pready,
  input  logic                    pslverr
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // Counter is sized to hold TIMEOUT; a 1-bit dummy when the timeout is off.
  localparam int CNT_WIDTH  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(TIMEOUT);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  write_q, write_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0] strb_q, strb_d;
  logic [2:0]            prot_q, prot_d;
  logic [CNT_WIDTH-1:0]  wait_q, wait_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic cmd_accept;
  logic timeout_hit;

  // Ready is combinational from pready so a new command can be taken in the
  // completing ACCESS cycle, giving back-to-back transfers with one SETUP gap.
  // Held low during reset so every output reads 0 while rst is asserted.
  assign cmd_ready  = !rst && ((state_q == ST_IDLE) ||
                               ((state_q == ST_ACCESS) && pready));
  assign cmd_accept = cmd_valid && cmd_ready;

  // The limit is hit in the ACCESS cycle that would bring the wait count up
  // to TIMEOUT; pready in that same cycle still completes normally.
  assign timeout_hit = (TIMEOUT != 0) && !pready &&
                       ((wait_q + CNT_WIDTH'(1)) == TIMEOUT_LIM);

  assign psel        = (state_q != ST_IDLE);
  assign penable     = (state_q == ST_ACCESS);
  assign paddr       = addr_q;
  assign pwrite      = write_q;
  assign pwdata      = wdata_q;
  assign pstrb       = strb_q;
  assign pprot       = prot_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;

  // Next-state logic: FSM, command capture, wait counter and response.
  // Response fields default to 0 so they are only non-zero with rsp_valid.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    write_d       = write_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    prot_d        = prot_q;
    wait_d        = wait_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept) state_d = ST_SETUP;
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
        wait_d  = '0;
      end
      ST_ACCESS: begin
        if (pready) begin
          rsp_valid_d = 1'b1;
          rsp_rdata_d = write_q ? '0 : prdata;
          rsp_err_d   = pslverr;
          state_d     = cmd_accept ? ST_SETUP : ST_IDLE;
        end else if (timeout_hit) begin
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          wait_d = wait_q + CNT_WIDTH'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Command fields are frozen here and held through SETUP and ACCESS.
    if (cmd_accept) begin
      addr_d  = cmd_addr;
      write_d = cmd_write;
      wdata_d = cmd_wdata;
      strb_d  = cmd_write ? cmd_strb : '0;
      prot_d  = cmd_prot;
    end
  end

  // State registers; async reset aborts any bus transfer immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      write_q       <= 1'b0;
      wdata_q       <= '0;
      strb_q        <= '0;
      prot_q        <= '0;
      wait_q        <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      write_q       <= write_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      prot_q        <= prot_d;
      wait_q        <= wait_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// ---------------------------------------------------------------------------
// tb_apb_master_bridge
//
// Directed testbench for apb_master_bridge. The bench plays both the command
// source and the APB slave, and checks bus timing and responses against
// hand-computed values.
// ---------------------------------------------------------------------------
module tb_apb_master_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_addr;
  logic        cmd_write;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_strb;
  logic [2:0]  cmd_prot;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checkCount = 0;
  int errorCount = 0;

  apb_master_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_addr   (cmd_addr),
    .cmd_write  (cmd_write),
    .cmd_wdata  (cmd_wdata),
    .cmd_strb   (cmd_strb),
    .cmd_prot   (cmd_prot),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .rsp_timeout(rsp_timeout),
    .paddr      (paddr),
    .psel       (psel),
    .penable    (penable),
    .pwrite     (pwrite),
    .pwdata     (pwdata),
    .pstrb      (pstrb),
    .pprot      (pprot),
    .prdata     (prdata),
    .pready     (pready),
    .pslverr    (pslverr)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock; inputs are changed and outputs sampled 2 units later.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // One complete transfer from IDLE: issue the command, answer as the slave
  // after 'waits' wait states, and check bus phases and the response.
  task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                               input logic [31:0] wdata, input logic [3:0] strb,
                               input logic [2:0] prot, input int waits,
                               input logic [31:0] rdata, input logic slverr);
    logic [3:0]  expStrb;
    logic [31:0] expRdata;
    expStrb  = wr ? strb : 4'h0;
    expRdata = wr ? 32'h0 : rdata;

    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    cmd_prot  = prot;
    #1;
    checkOutput("cmd_ready_idle", 32'(cmd_ready), 32'h1);
    step();
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_FFFF;
    checkOutput("setup_psel", 32'(psel), 32'h1);
    checkOutput("setup_penable", 32'(penable), 32'h0);
    checkOutput("setup_paddr", paddr, addr);
    checkOutput("setup_pwrite", 32'(pwrite), 32'(wr));
    checkOutput("setup_pwdata", pwdata, wdata);
    checkOutput("setup_pstrb", 32'(pstrb), 32'(expStrb));
    checkOutput("setup_pprot", 32'(pprot), 32'(prot));
    checkOutput("setup_cmd_ready", 32'(cmd_ready), 32'h0);
    step();
    for (int w = 0; w < waits; w++) begin
      pready  = 1'b0;
      pslverr = 1'b1;
      prdata  = 32'hDEAD_0000 + 32'(w);
      #1;
      checkOutput("wait_penable", 32'(penable), 32'h1);
      checkOutput("wait_cmd_ready", 32'(cmd_ready), 32'h0);
      checkOutput("wait_rsp_valid", 32'(rsp_valid), 32'h0);
      step();
    end
    pready  = 1'b1;
    pslverr = slverr;
    prdata  = rdata;
    #1;
    checkOutput("access_penable", 32'(penable), 32'h1);
    checkOutput("access_paddr", paddr, addr);
    checkOutput("access_cmd_ready", 32'(cmd_ready), 32'h1);
    step();
    pready  = 1'b0;
    pslverr = 1'b0;
    prdata  = 32'hBAAD_BAAD;
    checkOutput("rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rsp_rdata", rsp_rdata, expRdata);
    checkOutput("rsp_err", 32'(rsp_err), 32'(slverr));
    checkOutput("rsp_timeout", 32'(rsp_timeout), 32'h0);
    checkOutput("done_psel", 32'(psel), 32'h0);
    step();
    checkOutput("rsp_pulse_end", 32'(rsp_valid), 32'h0);
    checkOutput("rsp_err_idle", 32'(rsp_err), 32'h0);
  endtask

  initial begin
    int count;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_write = 1'b0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    cmd_prot  = '0;
    prdata    = '0;
    pready    = 1'b0;
    pslverr   = 1'b0;

    // Reset state: every output low.
    #1;
    checkOutput("rst_psel", 32'(psel), 32'h0);
    checkOutput("rst_penable", 32'(penable), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'h0);
    checkOutput("rst_paddr", paddr, 32'h0);
    step();
    step();
    rst = 1'b0;
    step();

    // Zero-wait write.
    applyStimulus(32'h10, 1'b1, 32'hA5A5_A5A5, 4'hF, 3'b000, 0, 32'h0, 1'b0);
    // Read with 3 wait states; strobes must be zeroed on reads.
    applyStimulus(32'h20, 1'b0, 32'h0, 4'hF, 3'b010, 3, 32'h1234_5678, 1'b0);
    // Slave error on completion.
    applyStimulus(32'h30, 1'b1, 32'h5555_AAAA, 4'h3, 3'b001, 1, 32'h0, 1'b1);
    // pready arrives on the 16th ACCESS cycle, the same cycle the limit hits.
    applyStimulus(32'h50, 1'b0, 32'h0, 4'h0, 3'b100, 15, 32'h0BAD_CAFE, 1'b0);

    // Back-to-back: second command is accepted in the first's completing cycle.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h40;
    cmd_write = 1'b1;
    cmd_wdata = 32'h1111_2222;
    cmd_strb  = 4'hC;
    cmd_prot  = 3'b000;
    step();
    checkOutput("b2b_setup1_paddr", paddr, 32'h40);
    step();
    cmd_addr  = 32'h44;
    cmd_write = 1'b0;
    pready    = 1'b1;
    prdata    = 32'h7777_7777;
    #1;
    checkOutput("b2b_access1_ready", 32'(cmd_ready), 32'h1);
    step();
    cmd_valid = 1'b0;
    pready    = 1'b0;
    checkOutput("b2b_gap_psel", 32'(psel), 32'h1);
    checkOutput("b2b_gap_penable", 32'(penable), 32'h0);
    checkOutput("b2b_gap_paddr", paddr, 32'h44);
    checkOutput("b2b_rsp1_valid", 32'(rsp_valid), 32'h1);
    checkOutput("b2b_rsp1_rdata", rsp_rdata, 32'h0);
    step();
    pready = 1'b1;
    prdata = 32'hCAFE_F00D;
    #1;
    checkOutput("b2b_access2_penable", 32'(penable), 32'h1);
    checkOutput("b2b_access2_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    pready = 1'b0;
    checkOutput("b2b_rsp2_valid", 32'(rsp_valid), 32'h1);
    checkOutput("b2b_rsp2_rdata", rsp_rdata, 32'hCAFE_F00D);
    checkOutput("b2b_end_psel", 32'(psel), 32'h0);
    step();

    // Hung slave: abort after 16 ACCESS cycles with a timeout response.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h80;
    cmd_write = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    pready = 1'b0;
    prdata = 32'hFFFF_0000;
    count  = 0;
    while (penable && count < 40) begin
      count++;
      step();
    end
    checkOutput("to_access_cycles", 32'(count), 32'd16);
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("to_rsp_err", 32'(rsp_err), 32'h1);
    checkOutput("to_rsp_timeout", 32'(rsp_timeout), 32'h1);
    checkOutput("to_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("to_psel", 32'(psel), 32'h0);
    step();
    checkOutput("to_rsp_end", 32'(rsp_valid), 32'h0);

    // Reset asserted in ACCESS: bus drops at once and no response follows.
    cmd_valid = 1'b1;
    cmd_addr  = 32'h60;
    cmd_write = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    checkOutput("mid_access_penable", 32'(penable), 32'h1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_psel", 32'(psel), 32'h0);
    checkOutput("mid_rst_penable", 32'(penable), 32'h0);
    checkOutput("mid_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    step();
    rst = 1'b0;
    step();
    checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'h0);
    applyStimulus(32'h70, 1'b0, 32'h0, 4'h0, 3'b011, 2, 32'h8765_4321, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Safety net so the run always ends even if the DUT stalls a wait.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
